hard_mem_1rw_d512_w64_req_adapter: RTL



---
 rtl/hard_mem_1rw_d512_w64_req_adapter_pkg.sv | 16 +
 rtl/hard_mem_1rw_resp_fifo.sv | 73 +++++++
 rtl/hard_mem_1rw_d512_w64_req_adapter.sv | 76 +++++++
 3 files changed

// File: rtl/hard_mem_1rw_d512_w64_req_adapter_pkg.sv
// Shared defaults and request type for the 512x64 1RW memory request adapter.
package hard_mem_1rw_d512_w64_req_adapter_pkg;

  localparam int width_default_lp      = 64;
  localparam int els_default_lp        = 512;
  localparam int addr_width_default_lp = $clog2(els_default_lp);
  // Three entries cover the two-cycle request-to-response loop at one read per cycle.
  localparam int resp_els_default_lp   = 3;

  typedef struct packed {
    logic                             w;
    logic [addr_width_default_lp-1:0] addr;
    logic [width_default_lp-1:0]      data;
  } req_s;

endpackage

// File: rtl/hard_mem_1rw_resp_fifo.sv
// Small 1r1w register FIFO holding captured read data until the consumer takes it.
// Pointers wrap modulo els_p so non-power-of-two depths work.
module hard_mem_1rw_resp_fifo
  import hard_mem_1rw_d512_w64_req_adapter_pkg::*;
#(
  parameter int width_p = width_default_lp,
  parameter int els_p   = resp_els_default_lp,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enq_v_i,
  input  logic [width_p-1:0]  enq_data_i,
  input  logic                deq_yumi_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  output logic [cnt_w_lp-1:0] count_o
);

  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;
  assign deq     = deq_yumi_i & v_o;

  // Storage; cleared on reset so data_o reads 0 while empty after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
    end else if (enq_v_i) begin
      mem_r[wr_ptr_r] <= enq_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; enqueue+dequeue together leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_v_i) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq)     rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({enq_v_i, deq})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Overflow guard: a push into a full FIFO is only legal alongside a pop.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(enq_v_i && !deq && (count_r == full_cnt_lp)))
        else $error("resp_fifo overflow");
    end
  end

endmodule

// File: rtl/hard_mem_1rw_d512_w64_req_adapter.sv
// Ready/valid front end for the 512x64 1RW hardened memory wrapper.
// Requests pass straight through to the wrapper pins; read data is captured the
// cycle after the access because the wrapper only holds data_o until the next access.
module hard_mem_1rw_d512_w64_req_adapter
  import hard_mem_1rw_d512_w64_req_adapter_pkg::*;
#(
  parameter int width_p    = width_default_lp,
  parameter int els_p      = els_default_lp,
  parameter int resp_els_p = resp_els_default_lp,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i
);

  localparam int cnt_w_lp = $clog2(resp_els_p + 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(resp_els_p);

  logic                inflight_r;
  logic [cnt_w_lp-1:0] count;
  logic [cnt_w_lp:0]   credit_used;

  // A slot is reserved for every read in the memory pipeline, so the FIFO can
  // never overflow even when the consumer stalls. Only registered state feeds ready_o.
  assign credit_used = {1'b0, count} + {{cnt_w_lp{1'b0}}, inflight_r};
  assign ready_o     = ~reset_i & (credit_used < {1'b0, full_cnt_lp});

  assign mem_v_o    = v_i & ready_o;
  assign mem_w_o    = w_i;
  assign mem_addr_o = addr_i;
  assign mem_data_o = data_i;

  // Tracks a read issued last cycle whose data is on mem_data_i now.
  always_ff @(posedge clk_i) begin
    if (reset_i) inflight_r <= 1'b0;
    else         inflight_r <= mem_v_o & ~mem_w_o;
  end

  hard_mem_1rw_resp_fifo #(
    .width_p (width_p),
    .els_p   (resp_els_p)
  ) resp_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .enq_v_i    (inflight_r),
    .enq_data_i (mem_data_i),
    .deq_yumi_i (yumi_i),
    .v_o        (v_o),
    .data_o     (data_o),
    .count_o    (count)
  );

  // Protocol checks on the consumer handshake and on the credit scheme.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("yumi_i asserted with no valid response");
      assert (!(inflight_r && (count == full_cnt_lp)))
        else $error("read capture with response FIFO full");
    end
  end

endmodule
